// File: rtl/vote_pkg.sv
// rtl/vote_pkg.sv - shared state encoding and seven-segment table for the vote board
package vote_pkg;

   typedef enum logic [1:0] {
      OPEN   = 2'd0,
      COUNT  = 2'd1,
      RESULT = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Segments are {g,f,e,d,c,b,a}, active-low.
   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchroniser and debouncer with rising-edge pulse
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic rise_p
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic             sync_1;
   logic             sync_2;
   logic [CNT_W-1:0] cnt;

   // The counter measures how long the synced level has differed from the accepted
   // level without interruption; any return to the accepted level restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
         cnt    <= '0;
         level  <= 1'b0;
         rise_p <= 1'b0;
      end else begin
         sync_1 <= raw;
         sync_2 <= sync_1;
         rise_p <= 1'b0;
         if (sync_2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt    <= '0;
            level  <= sync_2;
            rise_p <= sync_2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/vote_tally_display.sv
// rtl/vote_tally_display.sv - ballot latch, serial yes-vote tally and result display
module vote_tally_display
   import vote_pkg::*;
#(
   parameter int N_VOTERS        = 5,
   parameter int QUORUM          = 3,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_VOTERS-1:0] sw,
   input  logic                btn_cast,
   input  logic                btn_clear,
   output logic                led,
   output logic [6:0]          hex,
   output logic                locked
);

   localparam int CNT_W = $clog2(N_VOTERS + 1);
   localparam int IDX_W = (N_VOTERS > 1) ? $clog2(N_VOTERS) : 1;

   logic [N_VOTERS-1:0] sw_s1;
   logic [N_VOTERS-1:0] sw_s2;
   logic                cast_level;
   logic                clear_level;
   logic                cast_p;
   logic                clear_p;
   logic                unused_levels;
   state_t              state;
   logic [N_VOTERS-1:0] ballot;
   logic [CNT_W-1:0]    count;
   logic [IDX_W-1:0]    idx;
   logic [CNT_W-1:0]    next_count;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cast_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (btn_cast),
      .level  (cast_level),
      .rise_p (cast_p)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (btn_clear),
      .level  (clear_level),
      .rise_p (clear_p)
   );

   assign unused_levels = cast_level ^ clear_level;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_s1 <= '0;
         sw_s2 <= '0;
      end else begin
         sw_s1 <= sw;
         sw_s2 <= sw_s1;
      end
   end

   assign next_count = count + CNT_W'(ballot[idx]);

   // Outputs on entering RESULT are built from next_count so they appear together with locked.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= OPEN;
         ballot <= '0;
         count  <= '0;
         idx    <= '0;
         led    <= 1'b0;
         locked <= 1'b0;
         hex    <= SEG_BLANK;
      end else begin
         case (state)
            OPEN: begin
               if (cast_p && !clear_p) begin
                  ballot <= sw_s2;
                  count  <= '0;
                  idx    <= '0;
                  state  <= COUNT;
               end
            end
            COUNT: begin
               if (clear_p) begin
                  count <= '0;
                  idx   <= '0;
                  state <= OPEN;
               end else begin
                  count <= next_count;
                  idx   <= idx + 1'b1;
                  if (idx == IDX_W'(N_VOTERS - 1)) begin
                     state  <= RESULT;
                     locked <= 1'b1;
                     led    <= (int'(next_count) >= QUORUM);
                     hex    <= seg_decode(4'(next_count));
                  end
               end
            end
            RESULT: begin
               if (clear_p) begin
                  state  <= OPEN;
                  locked <= 1'b0;
                  led    <= 1'b0;
                  hex    <= SEG_BLANK;
               end
            end
            default: begin
               state  <= OPEN;
               locked <= 1'b0;
               led    <= 1'b0;
               hex    <= SEG_BLANK;
            end
         endcase
      end
   end

endmodule
